hub75_bcm_driver: RTL
=====================

# hub75_bcm_driver

Parametrised HUB75 dot-matrix panel driver with binary-code-modulated (BCM) colour depth, a built-in shift-clock divider and a synchronous framebuffer read port. It is the successor to the fixed 1-bit, 16-row matrix driver: it generalises panel width, row-address width and colour depth. It sits between the framebuffer RAM and the panel pins in the badge top level.

## Interface
- COLS, 64: columns per scan row (pixels shifted per plane); ≥2
- ROW_BITS, 4: row-address width; scan rows = 2**ROW_BITS
- BPC, 4: bits per colour channel (BCM planes); ≥1
- CLK_DIV, 6: clk cycles per tick; ≥2
- BASE_OE, 4: display ticks for plane 0; plane b displays BASE_OE<<b ticks; ≥1

- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- en  in  1  1 = scan panel; 0 = stop after current plane and blank
- pix_addr  out  ROW_BITS+clog2(COLS)  framebuffer address {row, col}
- pix_data  in  6*BPC  {top_r, top_g, top_b, bot_r, bot_g, bot_b}, valid 1 clk after pix_addr
- mat_r, mat_g, mat_b  out  2 each  colour bit of the current plane; [1] = top half, [0] = bottom half
- mat_row  out  ROW_BITS  panel row address
- mat_clk  out  1  panel shift clock
- mat_lat  out  1  panel latch, active-high
- mat_oe  out  1  panel output enable, active-low (1 = blanked)
- frame_start  out  1  one-clk pulse at the start of row 0, plane 0

## Operation
- Reset: mat_r/g/b = 0, mat_row = 0, mat_clk = 0, mat_lat = 0, mat_oe = 1, pix_addr = 0, frame_start = 0, tick counter = 0, state IDLE, row = 0, plane = 0.
- Tick divider: a counter counts 0..CLK_DIV-1 and wraps. A tick is the cycle where the counter = CLK_DIV-1. All state changes and pin changes occur on ticks only, except frame_start, which is a single clk pulse.
- States:
  - IDLE: mat_oe = 1. On a tick with en = 1, move to SHIFT with row = 0 and plane = 0, and pulse frame_start.
  - SHIFT: for col c = 0..COLS-1, two ticks per column.
    - Tick A: mat_clk = 0; mat_r/g/b = bit[plane] of each field of pix_data; pix_addr = {row, c+1} (no increment after the last column).
    - Tick B: mat_clk = 1.
    - pix_addr = {row, 0} is set on entry to SHIFT. CLK_DIV ≥ 2 guarantees the 1-clk RAM latency is met.
    - After tick B of col COLS-1, go to LATCH.
  - LATCH: tick 1: mat_clk = 0, mat_lat = 1, mat_row = row. Tick 2: mat_lat = 0, go to SHOW. mat_oe stays 1.
  - SHOW: mat_oe = 0 for exactly BASE_OE<<plane ticks, then go to BLANK.
  - BLANK: mat_oe = 1 for one tick, then advance.
    - If plane < BPC-1: plane+1.
    - Else: plane = 0 and row+1, wrapping 2**ROW_BITS-1 → 0. On the wrap, pulse frame_start on entry to SHIFT.
    - If en = 0: go to IDLE instead of SHIFT. Row and plane reset to 0; the next start is a fresh frame.
- en deasserted mid-plane has no effect until BLANK.
- mat_row changes only in LATCH while mat_oe = 1. mat_oe = 0 only in SHOW. mat_lat and mat_oe = 0 are never both active.
- Plane b carries weight 2**b. Duty per row is proportional to BASE_OE*(2**BPC-1).
- rst asserted in any state returns to reset values on the next clk edge, including mid-shift and mid-SHOW.

## Timing
- Ticks per plane b: 2*COLS + 2 + (BASE_OE<<b) + 1. The per-plane sequence is SHIFT → LATCH → SHOW → BLANK.
- Ticks per row: BPC*(2*COLS+3) + BASE_OE*(2**BPC-1).
- Ticks per frame: 2**ROW_BITS × ticks per row. Clk cycles = ticks × CLK_DIV.
- First tick: CLK_DIV-1 clks after rst falls. The first mat_clk rise occurs 2 ticks after leaving IDLE.
- The mat_clk period is 2*CLK_DIV clks with 50% duty. Data changes on the falling tick and is stable before the rising tick.
- frame_start is exactly 1 clk wide, once per frame.

## Test plan
- Reset: hold rst 3 clks mid-SHOW with COLS = 4, ROW_BITS = 2, BPC = 2, CLK_DIV = 2, BASE_OE = 1.
  - Required response: all outputs at reset values the clk after rst; mat_oe = 1.
  - Next frame_start occurs 2 clks after rst release, at the first tick with en = 1.
- Shift data: RAM holds pix_data with top_r = 2'b01 at col 1 only.
  - Plane 0: mat_r[1] = 1 only during the 2nd mat_clk pulse.
  - Plane 1: mat_r[1] = 0 for all 4 pulses.
  - Exactly 4 mat_clk rises occur per plane.
- BCM timing: same parameters.
  - mat_oe is low for 2 clks (1 tick) in plane 0 and 4 clks (2 ticks) in plane 1.
  - Row period = 2*(11) + 3 = 25 ticks = 50 clks.
- Row sequencing:
  - mat_row steps 0,1,2,3,0; each change occurs only while mat_lat = 1 and mat_oe = 1.
  - frame_start pulses every 200 clks.
- Enable:
  - Drop en mid-SHIFT of row 2. The plane completes through BLANK, then mat_oe stays 1 and mat_clk stays 0 in IDLE.
  - Re-raise en: frame_start fires, and the next latch sets mat_row = 0.
- Invariant checker (CLK_DIV = 3, COLS = 8, random en):
  - Never mat_oe = 0 with mat_lat = 1.
  - Never mat_row changes while mat_oe = 0.
  - The mat_clk high time is always 3 clks.

Source files
------------

// File: rtl/hub75_bcm_driver.sv
// HUB75 dot-matrix scanner with binary-code-modulated colour depth.
// Shifts one bit-plane of one row pair at a time from a synchronous framebuffer port.
module hub75_bcm_driver #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 4,
    parameter int BPC      = 4,
    parameter int CLK_DIV  = 6,
    parameter int BASE_OE  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    output logic [ROW_BITS+$clog2(COLS)-1:0]  pix_addr,
    input  logic [6*BPC-1:0]                  pix_data,
    output logic [1:0]                        mat_r,
    output logic [1:0]                        mat_g,
    output logic [1:0]                        mat_b,
    output logic [ROW_BITS-1:0]               mat_row,
    output logic                              mat_clk,
    output logic                              mat_lat,
    output logic                              mat_oe,
    output logic                              frame_start
);
    localparam int COL_BITS   = $clog2(COLS);
    localparam int DIV_BITS   = $clog2(CLK_DIV);
    localparam int PLANE_BITS = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int SHOW_BITS  = $clog2((BASE_OE << (BPC - 1)) + 1);

    localparam logic [COL_BITS-1:0]   LAST_COL   = COL_BITS'(COLS - 1);
    localparam logic [PLANE_BITS-1:0] LAST_PLANE = PLANE_BITS'(BPC - 1);
    localparam logic [DIV_BITS-1:0]   LAST_DIV   = DIV_BITS'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, LATCH, SHOW, BLANK} state_t;

    state_t                  state, state_nxt;
    logic [DIV_BITS-1:0]     div_cnt;
    logic                    tick;
    logic [COL_BITS-1:0]     col, col_nxt;
    logic                    phase, phase_nxt;
    logic [SHOW_BITS-1:0]    show_cnt, show_cnt_nxt;
    logic [SHOW_BITS-1:0]    show_len;
    logic [ROW_BITS-1:0]     row, row_nxt;
    logic [PLANE_BITS-1:0]   plane, plane_nxt;

    logic [ROW_BITS+COL_BITS-1:0] addr_nxt;
    logic [1:0]              r_nxt, g_nxt, b_nxt;
    logic [ROW_BITS-1:0]     mat_row_nxt;
    logic                    clk_nxt, lat_nxt, oe_nxt, fs_nxt;

    logic [BPC-1:0] top_r, top_g, top_b, bot_r, bot_g, bot_b;

    assign {top_r, top_g, top_b, bot_r, bot_g, bot_b} = pix_data;
    assign tick     = (div_cnt == LAST_DIV);
    assign show_len = SHOW_BITS'(BASE_OE) << plane;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            state       <= IDLE;
            col         <= '0;
            phase       <= 1'b0;
            show_cnt    <= '0;
            row         <= '0;
            plane       <= '0;
            pix_addr    <= '0;
            mat_r       <= '0;
            mat_g       <= '0;
            mat_b       <= '0;
            mat_row     <= '0;
            mat_clk     <= 1'b0;
            mat_lat     <= 1'b0;
            mat_oe      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= tick ? '0 : div_cnt + DIV_BITS'(1);
            state       <= state_nxt;
            col         <= col_nxt;
            phase       <= phase_nxt;
            show_cnt    <= show_cnt_nxt;
            row         <= row_nxt;
            plane       <= plane_nxt;
            pix_addr    <= addr_nxt;
            mat_r       <= r_nxt;
            mat_g       <= g_nxt;
            mat_b       <= b_nxt;
            mat_row     <= mat_row_nxt;
            mat_clk     <= clk_nxt;
            mat_lat     <= lat_nxt;
            mat_oe      <= oe_nxt;
            frame_start <= fs_nxt;
        end
    end

    // Everything, pins included, moves only on a tick; phase 0/1 is the falling/rising half of a column.
    always_comb begin
        state_nxt    = state;
        col_nxt      = col;
        phase_nxt    = phase;
        show_cnt_nxt = show_cnt;
        row_nxt      = row;
        plane_nxt    = plane;
        addr_nxt     = pix_addr;
        r_nxt        = mat_r;
        g_nxt        = mat_g;
        b_nxt        = mat_b;
        mat_row_nxt  = mat_row;
        clk_nxt      = mat_clk;
        lat_nxt      = mat_lat;
        oe_nxt       = mat_oe;
        fs_nxt       = 1'b0;

        if (tick) begin
            case (state)
                IDLE: begin
                    oe_nxt  = 1'b1;
                    clk_nxt = 1'b0;
                    if (en) begin
                        state_nxt = SHIFT;
                        row_nxt   = '0;
                        plane_nxt = '0;
                        col_nxt   = '0;
                        phase_nxt = 1'b0;
                        addr_nxt  = '0;
                        fs_nxt    = 1'b1;
                    end
                end
                SHIFT: begin
                    if (!phase) begin
                        clk_nxt   = 1'b0;
                        r_nxt     = {top_r[plane], bot_r[plane]};
                        g_nxt     = {top_g[plane], bot_g[plane]};
                        b_nxt     = {top_b[plane], bot_b[plane]};
                        phase_nxt = 1'b1;
                        if (col != LAST_COL) begin
                            addr_nxt = {row, col + COL_BITS'(1)};
                        end
                    end else begin
                        clk_nxt   = 1'b1;
                        phase_nxt = 1'b0;
                        if (col == LAST_COL) begin
                            state_nxt = LATCH;
                        end else begin
                            col_nxt = col + COL_BITS'(1);
                        end
                    end
                end
                LATCH: begin
                    // mat_lat itself tells the first latch tick from the second.
                    if (!mat_lat) begin
                        clk_nxt     = 1'b0;
                        lat_nxt     = 1'b1;
                        mat_row_nxt = row;
                    end else begin
                        lat_nxt      = 1'b0;
                        oe_nxt       = 1'b0;
                        show_cnt_nxt = '0;
                        state_nxt    = SHOW;
                    end
                end
                SHOW: begin
                    if (show_cnt == show_len - SHOW_BITS'(1)) begin
                        oe_nxt    = 1'b1;
                        state_nxt = BLANK;
                    end else begin
                        show_cnt_nxt = show_cnt + SHOW_BITS'(1);
                    end
                end
                BLANK: begin
                    col_nxt   = '0;
                    phase_nxt = 1'b0;
                    if (plane == LAST_PLANE) begin
                        plane_nxt = '0;
                        row_nxt   = row + ROW_BITS'(1);
                    end else begin
                        plane_nxt = plane + PLANE_BITS'(1);
                    end
                    if (!en) begin
                        state_nxt = IDLE;
                        row_nxt   = '0;
                        plane_nxt = '0;
                    end else begin
                        state_nxt = SHIFT;
                        addr_nxt  = {row_nxt, COL_BITS'(0)};
                        fs_nxt    = (row_nxt == '0) && (plane_nxt == '0);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule
